// File: rtl/peripheral_input_conditioner.sv
// Board-pin conditioner: synchronises and debounces buttons and switches, then derives edge pulses
// and per-button sticky press/overflow flags for the CPU-facing status bus.
module peripheral_input_conditioner #(
    parameter int NUM_BUTTONS     = 5,
    parameter int NUM_SWITCHES    = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_BUTTONS-1:0]              buttons_raw,
    input  logic [NUM_SWITCHES-1:0]             switches_raw,
    output logic [NUM_BUTTONS+NUM_SWITCHES-1:0] status_bus,
    output logic [NUM_BUTTONS-1:0]              press_pulse,
    output logic [NUM_BUTTONS-1:0]              release_pulse,
    output logic [NUM_SWITCHES-1:0]             switch_pulse,
    output logic [NUM_BUTTONS-1:0]              press_pending,
    output logic [NUM_BUTTONS-1:0]              press_overflow,
    input  logic [NUM_BUTTONS-1:0]              event_clear,
    output logic                                any_pending
);

    localparam int N  = NUM_BUTTONS + NUM_SWITCHES;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

    // Buttons occupy the MSBs throughout, so stable_q maps directly onto status_bus.
    logic [N-1:0]           raw;
    logic [N-1:0]           sync;
    logic [N-1:0]           sync_q [SYNC_STAGES];
    deb_state_e             state_q [N];
    logic [CW-1:0]          cnt_q [N];
    logic [N-1:0]           stable_q;
    logic [N-1:0]           rise_q;
    logic [N-1:0]           fall_q;
    logic [NUM_BUTTONS-1:0] pend_q;
    logic [NUM_BUTTONS-1:0] pend_d;
    logic [NUM_BUTTONS-1:0] ovf_q;
    logic [NUM_BUTTONS-1:0] ovf_d;
    logic [NUM_BUTTONS-1:0] press_evt;

    assign raw  = {buttons_raw, switches_raw};
    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Pulses are written in the same edge as the stable bit so both become visible together.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < N; i++) begin
                case (state_q[i])
                    ST_STABLE: begin
                        if (sync[i] != stable_q[i]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                stable_q[i] <= sync[i];
                                rise_q[i]   <= sync[i];
                                fall_q[i]   <= ~sync[i];
                            end else begin
                                cnt_q[i]   <= CW'(1);
                                state_q[i] <= ST_PENDING;
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (sync[i] == stable_q[i]) begin
                            cnt_q[i]   <= '0;
                            state_q[i] <= ST_STABLE;
                        end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                            stable_q[i] <= sync[i];
                            rise_q[i]   <= sync[i];
                            fall_q[i]   <= ~sync[i];
                            cnt_q[i]    <= '0;
                            state_q[i]  <= ST_STABLE;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // A press arriving with a clear sets pending but the clear still consumes any old overflow.
    always_comb begin
        press_evt = rise_q[N-1:NUM_SWITCHES];
        pend_d    = (pend_q & ~event_clear) | press_evt;
        ovf_d     = (ovf_q & ~event_clear) | (press_evt & pend_q & ~event_clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign status_bus     = stable_q;
    assign press_pulse    = rise_q[N-1:NUM_SWITCHES];
    assign release_pulse  = fall_q[N-1:NUM_SWITCHES];
    assign switch_pulse   = rise_q[NUM_SWITCHES-1:0] | fall_q[NUM_SWITCHES-1:0];
    assign press_pending  = pend_q;
    assign press_overflow = ovf_q;
    assign any_pending    = |pend_q;

endmodule

// File: tb/tb_peripheral_input_conditioner.sv
// Bench for peripheral_input_conditioner: directed scenarios plus randomized stimulus checked
// against a run-length reference model of the debounce and sticky-flag rules.
module tb_peripheral_input_conditioner;

    localparam int NB  = 5;
    localparam int NS  = 16;
    localparam int DEB = 4;
    localparam int SS  = 2;
    localparam int N   = NB + NS;
    localparam int OW  = N + NB + NB + NS + NB + NB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] buttons_raw = '0;
    logic [NS-1:0] switches_raw = '0;
    logic [NB-1:0] event_clear = '0;
    logic [N-1:0]  status_bus;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic [NS-1:0] switch_pulse;
    logic [NB-1:0] press_pending;
    logic [NB-1:0] press_overflow;
    logic          any_pending;

    int checks = 0;
    int errors = 0;

    peripheral_input_conditioner #(
        .NUM_BUTTONS(NB), .NUM_SWITCHES(NS), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .rst(rst), .buttons_raw(buttons_raw), .switches_raw(switches_raw),
        .status_bus(status_bus), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .switch_pulse(switch_pulse), .press_pending(press_pending),
        .press_overflow(press_overflow), .event_clear(event_clear), .any_pending(any_pending)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples pass through an SS-deep delay line; a bit's stable value flips
    // once DEB consecutive delayed samples disagree with it.
    logic [N-1:0]  m_pipe[$];
    logic [N-1:0]  m_stable = '0;
    logic [N-1:0]  m_rise = '0;
    logic [N-1:0]  m_fall = '0;
    logic [NB-1:0] m_pend = '0;
    logic [NB-1:0] m_ovf = '0;
    logic [NB-1:0] m_pp;
    logic [N-1:0]  m_seen;
    int            m_run[N];

    always @(posedge clk) begin
        if (rst) begin
            m_pipe = {};
            for (int k = 0; k < SS; k++) m_pipe.push_back('0);
            m_stable = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_ovf = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            m_seen = m_pipe.pop_front();
            m_pipe.push_back({buttons_raw, switches_raw});
            m_pp   = m_rise[N-1:NS];
            m_ovf  = (m_ovf & ~event_clear) | (m_pp & m_pend & ~event_clear);
            m_pend = (m_pend & ~event_clear) | m_pp;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (m_seen[i] != m_stable[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_stable[i] = m_seen[i];
                        m_run[i] = 0;
                        if (m_seen[i]) m_rise[i] = 1'b1;
                        else m_fall[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] all_out;
        rst = 1'b1; buttons_raw = '1; switches_raw = '1; event_clear = '0;
        repeat (3) begin
            step();
            all_out = {status_bus, press_pulse, release_pulse, switch_pulse,
                       press_pending, press_overflow, any_pending};
            checks++;
            if (all_out !== '0) begin
                errors++; $display("FAIL reset_outputs got %h exp 0", all_out);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (k < 6 && status_bus !== '0) begin
                errors++; $display("FAIL reset_early k=%0d got %h exp 0", k, status_bus);
            end
            if (k == 6 && (status_bus !== 21'h1FFFFF || press_pulse !== 5'h1F
                           || switch_pulse !== 16'hFFFF)) begin
                errors++; $display("FAIL reset_rise got %h/%h/%h exp 1fffff/1f/ffff",
                                   status_bus, press_pulse, switch_pulse);
            end
            if (k == 7 && (press_pulse !== 5'h00 || press_pending !== 5'h1F)) begin
                errors++; $display("FAIL reset_after got pulse %h pend %h exp 00/1f",
                                   press_pulse, press_pending);
            end
        end
        buttons_raw = '0; switches_raw = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 6) begin
                checks++;
                if (status_bus !== '0 || release_pulse !== 5'h1F || press_pulse !== '0) begin
                    errors++; $display("FAIL reset_release got %h/%h exp 0/1f",
                                       status_bus, release_pulse);
                end
            end
        end
        event_clear = '1;
        step();
        event_clear = '0;
        checks++;
        if (press_pending !== '0 || press_overflow !== '0 || any_pending !== 1'b0) begin
            errors++; $display("FAIL reset_clear got pend %h ovf %h exp 0/0",
                               press_pending, press_overflow);
        end
    endtask

    task automatic test_glitch();
        buttons_raw[4] = 1'b1;
        repeat (3) step();
        buttons_raw[4] = 1'b0;
        repeat (10) begin
            step();
            checks++;
            if (status_bus !== '0 || press_pulse !== '0 || release_pulse !== '0
                || press_pending !== '0) begin
                errors++; $display("FAIL glitch got status %h press %h rel %h pend %h exp 0",
                                   status_bus, press_pulse, release_pulse, press_pending);
            end
        end
    endtask

    task automatic test_clean_press();
        buttons_raw[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (k < 6 && (status_bus[16] !== 1'b0 || press_pulse !== '0)) begin
                errors++; $display("FAIL press_early k=%0d got %b/%h exp 0/0",
                                   k, status_bus[16], press_pulse);
            end
            if (k == 6 && (status_bus[16] !== 1'b1 || press_pulse !== 5'b00001)) begin
                errors++; $display("FAIL press_edge got %b/%h exp 1/01", status_bus[16], press_pulse);
            end
            if (k == 7 && (press_pulse !== '0 || press_pending !== 5'b00001
                           || any_pending !== 1'b1)) begin
                errors++; $display("FAIL press_pending got pulse %h pend %h any %b exp 00/01/1",
                                   press_pulse, press_pending, any_pending);
            end
        end
    endtask

    task automatic test_overflow_clear();
        buttons_raw[0] = 1'b0;
        repeat (8) step();
        buttons_raw[0] = 1'b1;
        repeat (8) step();
        checks++;
        if (press_pending !== 5'b00001 || press_overflow !== 5'b00001) begin
            errors++; $display("FAIL overflow got pend %h ovf %h exp 01/01",
                               press_pending, press_overflow);
        end
        event_clear = 5'b00001;
        step();
        event_clear = '0;
        checks++;
        if (press_pending !== '0 || press_overflow !== '0 || any_pending !== 1'b0) begin
            errors++; $display("FAIL overflow_clear got pend %h ovf %h exp 0/0",
                               press_pending, press_overflow);
        end
    endtask

    task automatic test_collision();
        int waited;
        buttons_raw[0] = 1'b0;
        repeat (8) step();
        buttons_raw[0] = 1'b1;
        repeat (8) step();
        checks++;
        if (press_pending !== 5'b00001 || press_overflow !== '0) begin
            errors++; $display("FAIL collision_setup got pend %h ovf %h exp 01/00",
                               press_pending, press_overflow);
        end
        buttons_raw[0] = 1'b0;
        repeat (8) step();
        buttons_raw[0] = 1'b1;
        waited = 0;
        while (press_pulse[0] !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (press_pulse[0] !== 1'b1) begin
            errors++; $display("FAIL collision_wait got no press_pulse after %0d cycles exp pulse", waited);
        end
        event_clear = 5'b00001;
        step();
        event_clear = '0;
        checks++;
        if (press_pending[0] !== 1'b1 || press_overflow[0] !== 1'b0) begin
            errors++; $display("FAIL collision got pend %b ovf %b exp 1/0",
                               press_pending[0], press_overflow[0]);
        end
        buttons_raw[0] = 1'b0;
        repeat (8) step();
        event_clear = '1;
        step();
        event_clear = '0;
    endtask

    task automatic test_switches();
        switches_raw = 16'hA5A5;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (k < 6 && switch_pulse !== '0) begin
                errors++; $display("FAIL switch_early k=%0d got %h exp 0", k, switch_pulse);
            end
            if (k == 6 && (switch_pulse !== 16'hA5A5 || status_bus[15:0] !== 16'hA5A5)) begin
                errors++; $display("FAIL switch_edge got %h/%h exp a5a5/a5a5",
                                   switch_pulse, status_bus[15:0]);
            end
            if (k == 7 && switch_pulse !== '0) begin
                errors++; $display("FAIL switch_after got %h exp 0", switch_pulse);
            end
        end
        switches_raw = '0;
        repeat (8) step();
        switches_raw = 16'h00FF;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (status_bus !== '0 || switch_pulse !== '0) begin
                errors++; $display("FAIL switch_reset k=%0d got %h/%h exp 0/0",
                                   k, status_bus, switch_pulse);
            end
        end
        repeat (3) step();
        switches_raw = '0;
        repeat (10) step();
    endtask

    task automatic test_random();
        int hold;
        logic [OW-1:0] got;
        logic [OW-1:0] exp;
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                buttons_raw  = buttons_raw ^ (NB'($urandom) & NB'($urandom));
                switches_raw = switches_raw ^ (NS'($urandom) & NS'($urandom) & NS'($urandom));
                hold = $urandom_range(1, 9);
            end
            hold--;
            event_clear = ($urandom_range(0, 5) == 0) ? NB'($urandom) : '0;
            step();
            got = {status_bus, press_pulse, release_pulse, switch_pulse,
                   press_pending, press_overflow, any_pending};
            exp = {m_stable, m_rise[N-1:NS], m_fall[N-1:NS], m_rise[NS-1:0] | m_fall[NS-1:0],
                   m_pend, m_ovf, |m_pend};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random c=%0d got %h exp %h", c, got, exp);
            end
        end
        event_clear = '0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_press();
        test_overflow_clear();
        test_collision();
        test_switches();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
